// File: rtl/instruction_memory.sv
// ---------------------------------------------------------------------------
// instruction_memory
//
// Instruction memory for the IF stage of the MIPS pipeline. Instructions are
// loaded one word per cycle through a write port. An internal write pointer
// advances after each write and stops once the memory is full. Instructions
// are read combinationally at the byte address on i_pc, and the word is
// assembled big-endian from the byte array.
//
// Ports:
//   i_clk               - clock; all state changes on its rising edge
//   i_reset             - synchronous active-high reset; clears every byte and
//                         the write pointer, and overrides a write on the
//                         same edge
//   i_instruction_write - write enable; stores one word per rising edge
//   i_pc                - byte address of the instruction to read
//   i_instruction       - word to store at the current write pointer
//   o_instruction       - word read at i_pc (combinational)
// ---------------------------------------------------------------------------
module instruction_memory #(
    parameter int WORD_SIZE_IN_BYTES = 4,
    parameter int MEM_SIZE_IN_WORDS  = 10
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_instruction_write,
    input  logic [$clog2(MEM_SIZE_IN_WORDS*WORD_SIZE_IN_BYTES)-1:0] i_pc,
    input  logic [WORD_SIZE_IN_BYTES*8-1:0]     i_instruction,
    output logic [WORD_SIZE_IN_BYTES*8-1:0]     o_instruction
);

    localparam int POINTER_SIZE = $clog2(MEM_SIZE_IN_WORDS*WORD_SIZE_IN_BYTES);
    localparam int MEM_BYTES    = MEM_SIZE_IN_WORDS*WORD_SIZE_IN_BYTES;
    localparam int WORD_BITS    = WORD_SIZE_IN_BYTES*8;
    localparam int OFFSET_BITS  = $clog2(WORD_SIZE_IN_BYTES);
    // The pointer must be able to hold MEM_SIZE_IN_WORDS itself, which is
    // the "full" value.
    localparam int WPTR_BITS    = $clog2(MEM_SIZE_IN_WORDS+1);

    localparam logic [WPTR_BITS-1:0]    LP_FULL  = WPTR_BITS'(MEM_SIZE_IN_WORDS);
    localparam logic [POINTER_SIZE-1:0] LP_WORDS = POINTER_SIZE'(MEM_SIZE_IN_WORDS);

    logic [7:0]              r_mem [0:MEM_BYTES-1];
    logic [WPTR_BITS-1:0]    r_write_pointer;

    logic                    w_full;
    logic                    w_write_enable;
    logic [POINTER_SIZE-1:0] w_write_base;
    logic [POINTER_SIZE-1:0] w_read_word_index;
    logic [POINTER_SIZE-1:0] w_read_base;

    assign w_full         = (r_write_pointer == LP_FULL);
    assign w_write_enable = i_instruction_write && !w_full;
    // Byte address of the first byte of the word being written.
    assign w_write_base   = POINTER_SIZE'(int'(r_write_pointer) * WORD_SIZE_IN_BYTES);

    // Dropping the byte-offset bits makes every read word-aligned.
    assign w_read_word_index = i_pc >> OFFSET_BITS;
    assign w_read_base       = w_read_word_index << OFFSET_BITS;

    // Storage and write pointer. Reset wins over a write on the same edge.
    // Once full, the pointer saturates and further writes are ignored.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_write_pointer <= '0;
        end else if (w_write_enable) begin
            // Big-endian: the lowest byte address receives the MSB.
            for (int b = 0; b < WORD_SIZE_IN_BYTES; b++) begin
                r_mem[w_write_base + POINTER_SIZE'(b)] <= i_instruction[WORD_BITS-1-8*b -: 8];
            end
            r_write_pointer <= r_write_pointer + 1'b1;
        end
    end

    // Combinational read. Addresses past the last word return zero.
    always_comb begin
        o_instruction = '0;
        if (w_read_word_index < LP_WORDS) begin
            for (int b = 0; b < WORD_SIZE_IN_BYTES; b++) begin
                o_instruction[WORD_BITS-1-8*b -: 8] = r_mem[w_read_base + POINTER_SIZE'(b)];
            end
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// ---------------------------------------------------------------------------
// tb_instruction_memory
//
// Directed bench for instruction_memory at default parameters (4-byte words,
// 10 words, 6-bit byte address). Each scenario task drives its own stimulus
// and compares o_instruction against hand-computed values.
// ---------------------------------------------------------------------------
module tb_instruction_memory;

    logic        i_clk;
    logic        i_reset;
    logic        i_instruction_write;
    logic [5:0]  i_pc;
    logic [31:0] i_instruction;
    logic [31:0] o_instruction;

    int total = 0;
    int bad   = 0;

    // Words for the sequential load, in write order.
    logic [31:0] loadWords [0:9] = '{
        32'h1234_5678, 32'h8C01_0004, 32'hDEAD_BEEF, 32'h0000_00FF, 32'hFF00_0000,
        32'hA5C3_3C5A, 32'h2002_0007, 32'h0123_4567, 32'hCAFE_F00D, 32'h7FFF_FFFE
    };

    instruction_memory #(
        .WORD_SIZE_IN_BYTES(4),
        .MEM_SIZE_IN_WORDS (10)
    ) dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_instruction_write(i_instruction_write),
        .i_pc               (i_pc),
        .i_instruction      (i_instruction),
        .o_instruction      (o_instruction)
    );

    initial i_clk = 1'b0;
    always #10 i_clk = ~i_clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Single-cycle write pulse; idle data is junk so an ungated write shows up.
    task automatic write_word(input logic [31:0] d);
        i_instruction       = d;
        i_instruction_write = 1'b1;
        tick();
        i_instruction_write = 1'b0;
        i_instruction       = 32'hA5A5_A5A5;
    endtask

    task automatic pulse_reset();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_reset             = 1'b1;
        i_instruction_write = 1'b1;
        i_instruction       = 32'hDEAD_BEEF;
        tick();
        for (int i = 0; i < 10; i++) begin
            i_pc = 6'(i*4);
            #1;
            total++;
            if (o_instruction !== 32'h0) begin
                bad++;
                $display("[TB] FAIL reset_word%0d got=%h want=%h", i, o_instruction, 32'h0);
            end
        end
        tick();
        tick();
        i_reset             = 1'b0;
        i_instruction_write = 1'b0;
    endtask

    task automatic test_sequential_load();
        // Word 0: read-during-write shows the old value before the edge.
        i_pc                = 6'd0;
        i_instruction       = loadWords[0];
        i_instruction_write = 1'b1;
        #1;
        total++;
        if (o_instruction !== 32'h0) begin
            bad++;
            $display("[TB] FAIL rdw_before got=%h want=%h", o_instruction, 32'h0);
        end
        tick();
        i_instruction_write = 1'b0;
        i_instruction       = 32'hA5A5_A5A5;
        total++;
        if (o_instruction !== loadWords[0]) begin
            bad++;
            $display("[TB] FAIL rdw_after got=%h want=%h", o_instruction, loadWords[0]);
        end
        for (int i = 1; i < 10; i++) begin
            i_pc = 6'(((i * 7) % 10) * 4);
            write_word(loadWords[i]);
            for (int g = 0; g < (i % 3); g++) tick();
        end
        for (int i = 0; i < 10; i++) begin
            i_pc = 6'(i*4);
            #1;
            total++;
            if (o_instruction !== loadWords[i]) begin
                bad++;
                $display("[TB] FAIL load_word%0d got=%h want=%h", i, o_instruction, loadWords[i]);
            end
        end
    endtask

    task automatic test_overflow();
        write_word(32'h0000_0000);
        i_instruction       = 32'hFFFF_FFFF;
        i_instruction_write = 1'b1;
        tick();
        tick();
        i_instruction_write = 1'b0;
        for (int i = 0; i < 10; i++) begin
            i_pc = 6'(i*4);
            #1;
            total++;
            if (o_instruction !== loadWords[i]) begin
                bad++;
                $display("[TB] FAIL overflow_word%0d got=%h want=%h", i, o_instruction, loadWords[i]);
            end
        end
    endtask

    task automatic test_address_edges();
        i_pc = 6'd5;  #1;
        total++;
        if (o_instruction !== 32'h8C01_0004) begin
            bad++;
            $display("[TB] FAIL pc5 got=%h want=%h", o_instruction, 32'h8C01_0004);
        end
        i_pc = 6'd7;  #1;
        total++;
        if (o_instruction !== 32'h8C01_0004) begin
            bad++;
            $display("[TB] FAIL pc7 got=%h want=%h", o_instruction, 32'h8C01_0004);
        end
        i_pc = 6'd39; #1;
        total++;
        if (o_instruction !== 32'h7FFF_FFFE) begin
            bad++;
            $display("[TB] FAIL pc39 got=%h want=%h", o_instruction, 32'h7FFF_FFFE);
        end
        i_pc = 6'd40; #1;
        total++;
        if (o_instruction !== 32'h0) begin
            bad++;
            $display("[TB] FAIL pc40 got=%h want=%h", o_instruction, 32'h0);
        end
        i_pc = 6'd63; #1;
        total++;
        if (o_instruction !== 32'h0) begin
            bad++;
            $display("[TB] FAIL pc63 got=%h want=%h", o_instruction, 32'h0);
        end
    endtask

    task automatic test_multi_cycle();
        logic [31:0] exp [0:3];
        exp = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'h0000_0000};
        pulse_reset();
        i_instruction_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_instruction = exp[i];
            tick();
        end
        i_instruction_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_pc = 6'(i*4);
            #1;
            total++;
            if (o_instruction !== exp[i]) begin
                bad++;
                $display("[TB] FAIL multi_word%0d got=%h want=%h", i, o_instruction, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        pulse_reset();
        for (int i = 0; i < 4; i++) write_word(loadWords[i]);
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            i_pc = 6'(i*4);
            #1;
            total++;
            if (o_instruction !== 32'h0) begin
                bad++;
                $display("[TB] FAIL midreset_word%0d got=%h want=%h", i, o_instruction, 32'h0);
            end
        end
        write_word(32'h1357_9BDF);
        i_pc = 6'd0; #1;
        total++;
        if (o_instruction !== 32'h1357_9BDF) begin
            bad++;
            $display("[TB] FAIL midreset_next got=%h want=%h", o_instruction, 32'h1357_9BDF);
        end
        i_pc = 6'd4; #1;
        total++;
        if (o_instruction !== 32'h0) begin
            bad++;
            $display("[TB] FAIL midreset_word1 got=%h want=%h", o_instruction, 32'h0);
        end
    endtask

    task automatic test_reset_priority();
        write_word(32'h1111_1111);
        write_word(32'h2222_2222);
        i_reset             = 1'b1;
        i_instruction_write = 1'b1;
        i_instruction       = 32'h9999_9999;
        tick();
        i_reset             = 1'b0;
        i_instruction_write = 1'b0;
        for (int i = 0; i < 10; i++) begin
            i_pc = 6'(i*4);
            #1;
            total++;
            if (o_instruction !== 32'h0) begin
                bad++;
                $display("[TB] FAIL prio_word%0d got=%h want=%h", i, o_instruction, 32'h0);
            end
        end
        // Dropped write must not have advanced the pointer.
        write_word(32'h0BAD_F00D);
        i_pc = 6'd0; #1;
        total++;
        if (o_instruction !== 32'h0BAD_F00D) begin
            bad++;
            $display("[TB] FAIL prio_next got=%h want=%h", o_instruction, 32'h0BAD_F00D);
        end
    endtask

    initial begin
        i_reset             = 1'b0;
        i_instruction_write = 1'b0;
        i_pc                = 6'd0;
        i_instruction       = 32'h0;
        test_reset();
        test_sequential_load();
        test_overflow();
        test_address_edges();
        test_multi_cycle();
        test_reset_mid_load();
        test_reset_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
